// File: rtl/uart_tx_bus_responder.sv
// Memory-mapped 8N1 UART transmitter on the core data bus, with a TX FIFO.
// Ports: clock/reset, bus_* load/store responder (comb read data), uart_tx.
module uart_tx_bus_responder #(
  parameter logic [31:0] BASE_ADDRESS    = 32'hFF00_0000,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  input  logic [2:0]  bus_format,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  output logic [31:0] bus_data_fetched,
  output logic        uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t state, state_nx;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   divisor;
  logic [15:0]   div_lat;
  logic [15:0]   timer;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;

  logic       hit, is_read, is_write;
  logic [1:0] offset;
  logic       wr_tx, wr_status, div_we;
  logic       empty, full, busy;
  logic       pop, push, bit_end;

  assign hit      = bus_address[31:4] == BASE_ADDRESS[31:4];
  assign offset   = bus_address[3:2];
  assign is_read  = hit && bus_read_enable;
  assign is_write = hit && bus_write_enable;

  assign wr_tx     = is_write && offset == 2'd0;
  assign wr_status = is_write && offset == 2'd1;
  assign div_we    = is_write && offset == 2'd2 &&
                     (bus_format == 3'b010 ||
                      (bus_format == 3'b001 && !bus_address[1]));

  assign empty   = count == '0;
  assign full    = count == CW'(FIFO_DEPTH);
  assign busy    = state != IDLE;
  assign bit_end = timer == '0;

  // A pop in the same cycle frees a slot for a push into a full FIFO.
  assign pop  = state == IDLE && !empty;
  assign push = wr_tx && (!full || pop);

  logic unused_wdata;
  assign unused_wdata = ^{bus_write_data[31:16]};

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= bus_write_data[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      divisor  <= DEFAULT_DIVISOR;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_tx && full && !pop)
        overflow <= 1'b1;
      else if (wr_status && bus_write_data[3])
        overflow <= 1'b0;
      if (div_we) divisor <= bus_write_data[15:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (!empty) state_nx = START;
      START: if (bit_end) state_nx = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_nx = STOP;
      STOP:  if (bit_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bit timer reloads from the divisor latched at frame start.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer   <= '0;
      shift   <= '0;
      bit_idx <= '0;
      div_lat <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            shift   <= mem[rptr];
            div_lat <= divisor;
            timer   <= divisor;
          end
        end
        START: begin
          if (bit_end) begin
            timer   <= div_lat;
            bit_idx <= '0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer   <= div_lat;
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        STOP: begin
          if (!bit_end) timer <= timer - 16'd1;
        end
        default: timer <= '0;
      endcase
    end
  end

  always_comb begin
    uart_tx = 1'b1;
    unique case (state)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = shift[0];
      default: uart_tx = 1'b1;
    endcase
  end

  logic [31:0] reg_word, lane_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    reg_word = '0;
    unique case (offset)
      2'd1: reg_word = {16'h0, 8'(count), 4'h0,
                        overflow, empty, full, busy};
      2'd2: reg_word = {16'h0, divisor};
      default: reg_word = '0;
    endcase
  end

  assign lane_word = reg_word >> {bus_address[1:0], 3'b000};
  assign rd_byte   = lane_word[7:0];
  assign rd_half   = bus_address[1] ? reg_word[31:16] : reg_word[15:0];

  always_comb begin
    bus_data_fetched = '0;
    if (is_read) begin
      unique case (1'b1)
        bus_format == 3'b000: bus_data_fetched = {{24{rd_byte[7]}}, rd_byte};
        bus_format == 3'b001: bus_data_fetched = {{16{rd_half[15]}}, rd_half};
        bus_format == 3'b010: bus_data_fetched = reg_word;
        bus_format == 3'b100: bus_data_fetched = {24'h0, rd_byte};
        bus_format == 3'b101: bus_data_fetched = {16'h0, rd_half};
        default:              bus_data_fetched = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_bus_responder.sv
// Directed self-checking bench for uart_tx_bus_responder.
// Second instance with a 128-deep FIFO exercises the signed count byte.
module tb_uart_tx_bus_responder;

  localparam logic [31:0] BASE = 32'hFF00_0000;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bus_address, bus_write_data;
  logic [2:0]  bus_format;
  logic        bus_read_enable, bus_write_enable;
  logic [31:0] bus_data_fetched, fetched2;
  logic        uart_tx, tx2;

  always #5 clock = ~clock;

  uart_tx_bus_responder u_dut (
    .clock(clock), .reset(reset),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_format(bus_format), .bus_read_enable(bus_read_enable),
    .bus_write_enable(bus_write_enable),
    .bus_data_fetched(bus_data_fetched), .uart_tx(uart_tx)
  );

  uart_tx_bus_responder #(.FIFO_DEPTH(128)) u_dut128 (
    .clock(clock), .reset(reset),
    .bus_address(bus_address), .bus_write_data(bus_write_data),
    .bus_format(bus_format), .bus_read_enable(bus_read_enable),
    .bus_write_enable(bus_write_enable),
    .bus_data_fetched(fetched2), .uart_tx(tx2)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] d, d2;
  int n, n1, lows;
  logic [9:0] pat;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] v, logic [2:0] f);
    bus_address = a;
    bus_write_data = v;
    bus_format = f;
    bus_write_enable = 1'b1;
    tick();
    bus_write_enable = 1'b0;
  endtask

  task automatic load(logic [31:0] a, logic [2:0] f,
                      output logic [31:0] r, output logic [31:0] r2);
    bus_address = a;
    bus_format = f;
    bus_read_enable = 1'b1;
    #1;
    r = bus_data_fetched;
    r2 = fetched2;
    bus_read_enable = 1'b0;
  endtask

  task automatic wait_level(logic v, int bound, output int cnt);
    cnt = 0;
    while (uart_tx !== v && cnt < bound) begin
      tick();
      cnt++;
    end
    if (uart_tx !== v) check("wait_timeout", {31'b0, uart_tx}, {31'b0, v});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bus_address = '0;
    bus_write_data = '0;
    bus_format = '0;
    bus_read_enable = 1'b0;
    bus_write_enable = 1'b0;
    do_reset();

    // reset state and read path
    check("rst_tx", {31'b0, uart_tx}, 32'd1);
    load(BASE + 4, F_W, d, d2);
    check("rst_status", d, 32'h4);
    load(BASE + 8, F_W, d, d2);
    check("rst_div", d, 32'd433);
    load(BASE + 0, F_W, d, d2);
    check("txdata_rd", d, 32'h0);
    load(BASE + 32'h14, F_W, d, d2);
    check("miss_rd", d, 32'h0);
    bus_address = BASE + 8;
    #1;
    check("no_re", bus_data_fetched, 32'h0);
    store(BASE + 32'h18, 32'd7, F_W);
    load(BASE + 8, F_W, d, d2);
    check("miss_wr", d, 32'd433);

    // same-cycle read and write: read sees pre-edge value
    bus_address = BASE + 8;
    bus_write_data = 32'd3;
    bus_format = F_W;
    bus_write_enable = 1'b1;
    bus_read_enable = 1'b1;
    #1;
    check("rw_old", bus_data_fetched, 32'd433);
    tick();
    bus_write_enable = 1'b0;
    bus_read_enable = 1'b0;
    load(BASE + 8, F_W, d, d2);
    check("rw_new", d, 32'd3);

    // single frame of 8'hA5 at 4 clocks per bit
    pat = 10'b1101001010;
    store(BASE, 32'h0000_00A5, F_B);
    check("idle_gap", {31'b0, uart_tx}, 32'd1);
    tick();
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("bit%0d", b), {31'b0, uart_tx}, {31'b0, pat[b]});
        if (b == 0 && k == 1) begin
          load(BASE + 4, F_W, d, d2);
          check("busy", d, 32'h5);
        end
        tick();
      end
    end
    load(BASE + 4, F_W, d, d2);
    check("done_status", d, 32'h4);

    // fill, overflow, clear, streaming gap
    for (int i = 0; i < 9; i++) store(BASE, 32'hFF, F_B);
    load(BASE + 4, F_W, d, d2);
    check("full_status", d, 32'h0803);
    store(BASE, 32'hFF, F_B);
    load(BASE + 4, F_W, d, d2);
    check("ovf_status", d, 32'h080B);
    load(BASE + 5, F_B, d, d2);
    check("lb_count", d, 32'h8);
    load(BASE + 4, F_BU, d, d2);
    check("lbu_low", d, 32'h0B);
    load(BASE + 4, F_H, d, d2);
    check("lh_status", d, 32'h080B);
    store(BASE + 4, 32'h8, F_W);
    load(BASE + 4, F_W, d, d2);
    check("ovf_clear", d, 32'h0803);
    store(BASE + 32'hC, 32'hFFFF_FFFF, F_W);
    load(BASE + 32'hC, F_W, d, d2);
    check("reserved", d, 32'h0);
    wait_level(1'b1, 60, n);
    wait_level(1'b0, 60, n);
    wait_level(1'b1, 60, n1);
    wait_level(1'b0, 60, n);
    check("start_len", n1, 4);
    check("frame_period", n1 + n, 41);
    for (int i = 0; i < 500; i++) begin
      load(BASE + 4, F_W, d, d2);
      if (d == 32'h4) break;
      tick();
    end
    check("drained", d, 32'h4);

    // 128-deep build: count byte 0x80 sign/zero extension
    do_reset();
    for (int i = 0; i < 129; i++) store(BASE, i, F_B);
    load(BASE + 5, F_B, d, d2);
    check("lb_80", d2, 32'hFFFF_FF80);
    load(BASE + 5, F_BU, d, d2);
    check("lbu_80", d2, 32'h0000_0080);
    load(BASE + 4, F_W, d, d2);
    check("full128", d2, 32'h8003);
    store(BASE, 32'h55, F_B);
    load(BASE + 4, F_W, d, d2);
    check("ovf128", d2, 32'h800B);

    // divisor change mid-frame applies to next frame only
    do_reset();
    store(BASE + 8, 32'd3, F_W);
    store(BASE, 32'hFF, F_B);
    store(BASE, 32'hFF, F_B);
    wait_level(1'b0, 20, n);
    store(BASE + 8, 32'd7, F_W);
    wait_level(1'b1, 20, n);
    check("old_div_len", n + 1, 4);
    load(BASE + 8, F_W, d, d2);
    check("div_7", d, 32'd7);
    wait_level(1'b0, 80, n);
    wait_level(1'b1, 20, n);
    check("new_div_len", n, 8);
    store(BASE + 32'hA, 32'h55, F_H);
    store(BASE + 8, 32'h22, F_B);
    load(BASE + 8, F_W, d, d2);
    check("div_ignored", d, 32'd7);
    store(BASE + 8, 32'hABCD_0009, F_H);
    load(BASE + 8, F_W, d, d2);
    check("div_half", d, 32'd9);

    // reset during DATA with 3 bytes queued
    do_reset();
    store(BASE + 8, 32'd3, F_W);
    for (int i = 0; i < 4; i++) store(BASE, 32'h00, F_B);
    tick();
    tick();
    tick();
    check("in_data", {31'b0, uart_tx}, 32'd0);
    reset = 1'b1;
    tick();
    check("rst_mid_tx", {31'b0, uart_tx}, 32'd1);
    reset = 1'b0;
    load(BASE + 4, F_W, d, d2);
    check("rst_mid_status", d, 32'h4);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      if (uart_tx !== 1'b1) lows++;
      tick();
    end
    check("no_frames", lows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
